// File: rtl/demap_pkg.sv
// demap_pkg: shared modulation-order type and per-order LLR count for the QAM soft demapper
package demap_pkg;
  typedef enum logic [1:0] {BPSK, QPSK, QAM16, QAM64} mod_order_t;
  localparam int MAX_QM = 6;
  function automatic logic [2:0] qm(mod_order_t m);
    return m == BPSK ? 3'd1 : m == QPSK ? 3'd2 : m == QAM16 ? 3'd4 : 3'd6;
  endfunction
endpackage

// File: rtl/demap_llr_calc.sv
// demap_llr_calc: max-log LLR arithmetic for one symbol, saturated to IQ_DW then scaled down to LLR_DW
module demap_llr_calc
  import demap_pkg::*;
#(
  parameter int IQ_DW    = 16,
  parameter int LLR_DW   = 8,
  parameter int THR16    = 10362,
  parameter int THR64_HI = 10112,
  parameter int THR64_LO = 5056
) (
  input  logic signed [IQ_DW-1:0]         i_val,
  input  logic signed [IQ_DW-1:0]         q_val,
  input  logic        [IQ_DW:0]           abs_i,
  input  logic        [IQ_DW:0]           abs_q,
  input  mod_order_t                      order,
  output logic [MAX_QM-1:0][LLR_DW-1:0]   llr,
  output logic [MAX_QM-1:0]               sat
);
  localparam int W  = IQ_DW + 2;
  localparam int SH = IQ_DW - LLR_DW;
  typedef logic signed [W-1:0] wide_t;
  localparam wide_t MAXV = wide_t'((longint'(1) << (IQ_DW - 1)) - 1);
  localparam wide_t MINV = -MAXV - wide_t'(1);
  wide_t x [MAX_QM];
  wide_t thr_a, d_i, d_q;
  always_comb begin
    thr_a = order == QAM16 ? wide_t'(THR16) : wide_t'(THR64_HI);
    d_i   = wide_t'(THR64_HI) - wide_t'({1'b0, abs_i});
    d_q   = wide_t'(THR64_HI) - wide_t'({1'b0, abs_q});
    x[0]  = order == BPSK ? wide_t'(i_val) + wide_t'(q_val) : wide_t'(i_val);
    x[1]  = wide_t'(q_val);
    x[2]  = thr_a - wide_t'({1'b0, abs_i});
    x[3]  = thr_a - wide_t'({1'b0, abs_q});
    x[4]  = wide_t'(THR64_LO) - (d_i[W-1] ? -d_i : d_i);
    x[5]  = wide_t'(THR64_LO) - (d_q[W-1] ? -d_q : d_q);
  end
  for (genvar k = 0; k < MAX_QM; k++) begin : g_sat
    logic signed [IQ_DW-1:0] c;
    assign sat[k] = x[k] > MAXV || x[k] < MINV;
    assign c      = x[k] > MAXV ? MAXV[IQ_DW-1:0] : x[k] < MINV ? MINV[IQ_DW-1:0] : x[k][IQ_DW-1:0];
    assign llr[k] = LLR_DW'(c >>> SH);
  end
endmodule

// File: rtl/demap_qam.sv
// demap_qam: per-symbol BPSK/QPSK/16QAM/64QAM soft demapper, one LLR per beat with AXI-stream backpressure.
// Define DEMAP_SAT_CNT_EN to add sat_cnt_o, a saturating count of clipped LLRs emitted.
module demap_qam
  import demap_pkg::*;
#(
  parameter int         IQ_DW    = 16,
  parameter int         LLR_DW   = 8,
  parameter logic [1:0] USER_SEL = 2'd1,
  parameter int         THR16    = 10362,
  parameter int         THR64_HI = 10112,
  parameter int         THR64_LO = 5056
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [2*IQ_DW-1:0]  s_axis_in_tdata,
  input  logic [1:0]          s_axis_in_tuser,
  input  logic                s_axis_in_tlast,
  input  logic                s_axis_in_tvalid,
  output logic                s_axis_in_tready,
  input  logic [1:0]          mod_order_i,
  output logic [LLR_DW-1:0]   m_axis_out_tdata,
  output logic [1:0]          m_axis_out_tuser,
  output logic                m_axis_out_tlast,
  output logic                m_axis_out_tvalid,
  input  logic                m_axis_out_tready
`ifdef DEMAP_SAT_CNT_EN
  , output logic [15:0]       sat_cnt_o
`endif
);
  if (LLR_DW > IQ_DW) begin : g_width_err
    $error("demap_qam: LLR_DW must not exceed IQ_DW");
  end
  logic signed [IQ_DW-1:0] in_i, in_q, s1_i, s1_q;
  logic signed [IQ_DW:0] ext_i, ext_q;
  logic [IQ_DW:0] in_ai, in_aq, s1_ai, s1_aq;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic [1:0] s1_user, s2_user;
  mod_order_t s1_mod;
  logic [2:0] s2_qm, cnt;
  logic [MAX_QM-1:0][LLR_DW-1:0] llr, s2_llr;
  logic [MAX_QM-1:0] sat, s2_sat;
  logic in_hs, out_hs, s2_done, s1_adv;
  assign in_i  = s_axis_in_tdata[IQ_DW-1:0];
  assign in_q  = s_axis_in_tdata[2*IQ_DW-1:IQ_DW];
  assign ext_i = {in_i[IQ_DW-1], in_i};
  assign ext_q = {in_q[IQ_DW-1], in_q};
  assign in_ai = ext_i[IQ_DW] ? -ext_i : ext_i;
  assign in_aq = ext_q[IQ_DW] ? -ext_q : ext_q;
  assign out_hs  = s2_valid && m_axis_out_tready;
  assign s2_done = out_hs && cnt == s2_qm - 3'd1;
  assign s1_adv  = s1_valid && (!s2_valid || s2_done);
  assign s_axis_in_tready = reset_ni && (!s1_valid || s1_adv);
  assign in_hs = s_axis_in_tvalid && s_axis_in_tready;
  assign m_axis_out_tvalid = s2_valid;
  assign m_axis_out_tdata  = s2_llr[cnt];
  assign m_axis_out_tuser  = s2_user;
  assign m_axis_out_tlast  = s2_valid && s2_last && cnt == s2_qm - 3'd1;
  // Symbols with a foreign tuser are handshaken but never occupy S1
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      s1_ai    <= '0;
      s1_aq    <= '0;
      s1_mod   <= BPSK;
      s1_user  <= '0;
      s1_last  <= 1'b0;
    end else if (!s1_valid || s1_adv) begin
      s1_valid <= in_hs && s_axis_in_tuser == USER_SEL;
      if (in_hs) begin
        s1_i    <= in_i;
        s1_q    <= in_q;
        s1_ai   <= in_ai;
        s1_aq   <= in_aq;
        s1_mod  <= mod_order_t'(mod_order_i);
        s1_user <= s_axis_in_tuser;
        s1_last <= s_axis_in_tlast;
      end
    end
  end
  demap_llr_calc #(
    .IQ_DW(IQ_DW), .LLR_DW(LLR_DW), .THR16(THR16), .THR64_HI(THR64_HI), .THR64_LO(THR64_LO)
  ) u_calc (
    .i_val(s1_i), .q_val(s1_q), .abs_i(s1_ai), .abs_q(s1_aq), .order(s1_mod), .llr(llr), .sat(sat)
  );
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s2_valid <= 1'b0;
      s2_llr   <= '0;
      s2_sat   <= '0;
      s2_qm    <= 3'd1;
      s2_user  <= '0;
      s2_last  <= 1'b0;
      cnt      <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_llr   <= llr;
      s2_sat   <= sat;
      s2_qm    <= qm(s1_mod);
      s2_user  <= s1_user;
      s2_last  <= s1_last;
      cnt      <= '0;
    end else if (out_hs) begin
      s2_valid <= !s2_done;
      cnt      <= s2_done ? 3'd0 : cnt + 3'd1;
    end
  end
`ifdef DEMAP_SAT_CNT_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sat_cnt_o <= '0;
    else if (out_hs && s2_sat[cnt] && sat_cnt_o != 16'hFFFF) sat_cnt_o <= sat_cnt_o + 16'd1;
  end
`else
  logic unused_sat;
  assign unused_sat = ^s2_sat;
`endif
endmodule
